// File: rtl/prog_mem_loader_if.sv
// Boot download bus: incoming byte stream handshake plus the
// program memory write port driven by the loader.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // Host side: supplies bytes, observes the memory write port.
    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    // Loader side: consumes bytes, drives the memory write port.
    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Boot-time program memory loader: assembles little-endian bytes into
// 32-bit words, writes them one per cycle, checks a trailing XOR
// checksum and releases the core reset only after a clean load.
module prog_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    prog_mem_loader_if.slave  bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       asm_q, asm_d;      // lower three bytes of the word in flight
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic              count_ok;
    logic              last_word;

    // Byte acceptance is a pure decode of the current state.
    always_comb begin
        bus.byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
    end

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign count_ok  = (word_count != '0) && (word_count <= (ADDR_W+1)'(DEPTH));
    assign last_word = ({1'b0, widx_q} == (count_q - (ADDR_W+1)'(1)));

    // Next-state and next-output decode; abort overrides any byte or write step.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        widx_d    = widx_q;
        bidx_d    = bidx_q;
        csum_d    = csum_q;
        asm_d     = asm_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (count_ok) begin
                        state_d   = S_RECV;
                        count_d   = word_count;
                        widx_d    = '0;
                        bidx_d    = '0;
                        csum_d    = '0;
                        asm_d     = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                        cpu_rst_d = 1'b1;
                    end else begin
                        state_d   = S_ERR;
                        busy_d    = 1'b0;
                        done_d    = 1'b0;
                        error_d   = 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                end
            end

            S_RECV: begin
                if (abort) begin
                    state_d   = S_ERR;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                    cpu_rst_d = 1'b1;
                end else if (xfer) begin
                    csum_d = csum_q ^ bus.byte_in;
                    case (bidx_q)
                        2'd0: begin
                            asm_d[7:0] = bus.byte_in;
                            bidx_d     = 2'd1;
                        end
                        2'd1: begin
                            asm_d[15:8] = bus.byte_in;
                            bidx_d      = 2'd2;
                        end
                        2'd2: begin
                            asm_d[23:16] = bus.byte_in;
                            bidx_d       = 2'd3;
                        end
                        default: begin
                            // Write port is loaded here so mem_we is high
                            // exactly for the WRITE cycle that follows.
                            state_d = S_WRITE;
                            bidx_d  = '0;
                            we_d    = 1'b1;
                            waddr_d = widx_q;
                            wdata_d = {bus.byte_in, asm_q};
                        end
                    endcase
                end
            end

            S_WRITE: begin
                if (abort) begin
                    state_d   = S_ERR;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                    cpu_rst_d = 1'b1;
                end else if (last_word) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_RECV;
                    widx_d  = widx_q + ADDR_W'(1);
                end
            end

            S_CHECK: begin
                if (abort) begin
                    state_d   = S_ERR;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                    cpu_rst_d = 1'b1;
                end else if (xfer) begin
                    busy_d = 1'b0;
                    if (bus.byte_in == csum_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = S_ERR;
                        error_d   = 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            widx_q    <= '0;
            bidx_q    <= '0;
            csum_q    <= '0;
            asm_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            widx_q    <= widx_d;
            bidx_q    <= bidx_d;
            csum_q    <= csum_d;
            asm_q     <= asm_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

    // Structural invariants of the load sequence.
    a_we_in_write: assert property (@(posedge clk) disable iff (rst)
        we_q |-> (state_q == S_WRITE));
    a_busy_state: assert property (@(posedge clk) disable iff (rst)
        busy_q |-> (state_q == S_RECV || state_q == S_WRITE || state_q == S_CHECK));
    a_done_xor_err: assert property (@(posedge clk) disable iff (rst)
        !(done_q && error_q));
    a_done_runs: assert property (@(posedge clk) disable iff (rst)
        done_q |-> !cpu_rst_q);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed and randomized loads
// checked against a word-level model of the download protocol.
module tb_prog_mem_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   word_count;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;

    prog_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .bus        (bus),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [31:0] words [0:DEPTH-1];
    int unsigned exp_addr [$];
    logic [31:0] exp_data [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"},      bus.mem_we, 0);
        check({tag, "_waddr"},   bus.mem_waddr, 0);
        check({tag, "_wdata"},   bus.mem_wdata, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 1);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_error"},   error, 0);
        check({tag, "_rdy"},     bus.byte_ready, 0);
    endtask

    task automatic fill_random(input int n);
        for (int w = 0; w < n; w++) words[w] = $urandom;
    endtask

    // Every write must match the next word the model expects, and no
    // byte may be accepted while a write is in progress.
    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            check("we_rdy", bus.byte_ready, 0);
            check("we_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) begin
                check("we_addr", bus.mem_waddr, exp_addr.pop_front());
                check("we_data", bus.mem_wdata, exp_data.pop_front());
            end
        end
    end

    // mode: 0 valid held high, 1 valid toggles, 2 random valid.
    // abort_at: raise abort once that many bytes were accepted (-1: never).
    task automatic do_load(input int n, input int mode, input logic [7:0] sum_flip,
                           input int abort_at, input bit busy_start);
        logic [7:0] stream [$];
        logic [7:0] sum;
        logic [7:0] b;
        int ptr;
        int edges;
        int nw;
        int budget;
        bit aborted;
        bit v;
        bit ok;
        sum = 8'h00;
        ptr = 0;
        edges = 0;
        aborted = 1'b0;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(words[w] >> (8 * k));
                stream.push_back(b);
                sum ^= b;
            end
        end
        stream.push_back(sum ^ sum_flip);
        nw = (abort_at < 0) ? n : abort_at / 4;
        for (int w = 0; w < nw; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back(words[w]);
        end
        budget = 20 * (4 * n + 1) + 20;

        word_count = (ADDR_W+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("cpu_rst_after_start", cpu_rst, 1);
        check("done_after_start", done, 0);
        check("error_after_start", error, 0);

        while (!(done || error) && edges < budget) begin
            if (busy_start && edges == 3) begin
                start = 1'b1;
                word_count = (ADDR_W+1)'($urandom_range(0, 2047));
            end
            if (abort_at >= 0 && !aborted && ptr == abort_at) begin
                abort = 1'b1;
                bus.byte_valid = 1'b0;
                aborted = 1'b1;
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (edges % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.byte_valid = v && (ptr < stream.size());
                bus.byte_in = bus.byte_valid ? stream[ptr] : 8'($urandom);
                if (bus.byte_valid && bus.byte_ready) ptr++;
            end
            @(negedge clk);
            edges++;
            start = 1'b0;
            abort = 1'b0;
            word_count = (ADDR_W+1)'(n);
            if (!done) check("cpu_rst_held", cpu_rst, 1);
        end
        bus.byte_valid = 1'b0;

        ok = (abort_at < 0) && (sum_flip == 8'h00);
        check("timeout", edges < budget, 1);
        check("done_end", done, ok);
        check("error_end", error, !ok);
        check("cpu_rst_end", cpu_rst, !ok);
        check("busy_end", busy, 0);
        check("bytes_used", ptr, (abort_at < 0) ? stream.size() : abort_at);
        if (mode == 0 && abort_at < 0) check("latency", edges, 5 * n + 1);
        check("writes_left", exp_addr.size(), 0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic illegal_start(input int len);
        word_count = (ADDR_W+1)'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_error", error, 1);
        check("illegal_done", done, 0);
        check("illegal_busy", busy, 0);
        check("illegal_cpu_rst", cpu_rst, 1);
        check("illegal_rdy", bus.byte_ready, 0);
        @(negedge clk);
        check("illegal_no_we", bus.mem_we, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        // Single word.
        words[0] = 32'h00100093;
        do_load(1, 0, 8'h00, -1, 1'b0);

        // Two words, valid toggling.
        words[0] = 32'h00100093;
        words[1] = 32'h00200113;
        do_load(2, 1, 8'h00, -1, 1'b0);

        // Bad checksum (0x84 instead of 0x83).
        words[0] = 32'h00100093;
        do_load(1, 0, 8'h07, -1, 1'b0);

        // Illegal lengths.
        illegal_start(0);
        illegal_start(1025);
        illegal_start(2047);

        // Abort after 6 bytes of a 3-word load, then a clean load.
        fill_random(3);
        do_load(3, 0, 8'h00, 6, 1'b0);
        fill_random(2);
        do_load(2, 2, 8'h00, -1, 1'b0);

        // Reset in the middle of RECV.
        word_count = (ADDR_W+1)'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h5a;
        @(negedge clk);
        bus.byte_in = 8'ha5;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        fill_random(1);
        do_load(1, 0, 8'h00, -1, 1'b0);

        // Reload from DONE, with a start pulse while busy.
        fill_random(1);
        do_load(1, 0, 8'h00, -1, 1'b1);
        illegal_start(0);

        // Full-depth load, last address 1023.
        fill_random(DEPTH);
        do_load(DEPTH, 0, 8'h00, -1, 1'b0);

        // Randomized loads.
        for (int i = 0; i < 10; i++) begin
            int n;
            int ab;
            logic [7:0] flip;
            n = $urandom_range(1, 6);
            fill_random(n);
            flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n) : -1;
            do_load(n, $urandom_range(0, 2), flip, ab, (ab < 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Boot-time controller that fills the 1024 x 32-bit instruction memory from a byte stream before the core runs. It assembles little-endian bytes into 32-bit words and drives the memory write port one word per write cycle. It verifies a trailing XOR checksum and holds the core in reset until a load completes with a matching checksum. It sits between the external download interface and the program memory write port, alongside the core's fetch path.

Parameters:
ADDR_W, 10, word-address width of program memory
DEPTH, 1024, number of 32-bit words in program memory

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin load; sampled only in IDLE, DONE, ERR
word_count  input  ADDR_W+1  number of words to load, latched when start is accepted
abort  input  1  cancel an in-progress load
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts byte this cycle
mem_we  output  1  program memory write enable, one-cycle pulse per word
mem_waddr  output  ADDR_W  write word address
mem_wdata  output  32  write data
cpu_rst  output  1  core reset, active-high
busy  output  1  load in progress
done  output  1  last load succeeded
error  output  1  last load failed

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high. All outputs are registered except byte_ready, which is decoded from state.
- Reset values: state=IDLE, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, byte_ready=0. Internal word index, byte index and checksum are all 0.
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR.
- IDLE / DONE / ERR with start=1:
  - If 1 <= word_count <= DEPTH: latch the count, clear word index, byte index and checksum, then go to RECV. On the same edge set busy=1, done=0, error=0, cpu_rst=1.
  - Otherwise go to ERR with error=1.
- RECV:
  - byte_ready=1. A byte transfers when byte_valid && byte_ready.
  - Byte k (k = 0..3) is placed in mem_wdata[8k+7:8k] (little-endian), and checksum ^= byte_in.
  - When k=3 is accepted, go to WRITE and reset k to 0.
- WRITE:
  - byte_ready=0. mem_we=1 for exactly this one cycle, with mem_waddr equal to the word index.
  - If word index == count-1, go to CHECK; otherwise increment the word index and go to RECV.
- CHECK:
  - byte_ready=1. On transfer, compare byte_in with the checksum.
  - Match: go to DONE with done=1, busy=0, cpu_rst=0.
  - Mismatch: go to ERR with error=1, busy=0, cpu_rst=1.
- DONE: the core runs (cpu_rst=0). start re-enters a load and reasserts cpu_rst on the accepting edge.
- ERR: cpu_rst stays 1 until a successful load.
- abort=1 in RECV, WRITE or CHECK:
  - Go to ERR on the next edge; abort has priority over a simultaneous byte transfer or write.
  - A WRITE-cycle mem_we already driven in that cycle still occurs.
  - Memory content is not rolled back.
- start while busy is ignored.
- Throughput: with byte_valid held high, each word takes 5 cycles (4 accepts + 1 write). N words finish in 5N+1 cycles after the start edge; done is high on cycle 5N+2.
- mem_waddr and mem_wdata hold their last value when mem_we=0.
- Word index never exceeds DEPTH-1. word_count=DEPTH writes addresses 0..1023 with no wrap.
- rst mid-load: immediate return to reset values. Partially written memory is left as is.

Test Plan:
- Single word: start with word_count=1, then bytes 93,00,10,00,83 back-to-back -> one mem_we pulse with addr 0 and data 0x00100093; done=1 and cpu_rst=0 at cycle 7 after start.
- Two words: bytes 93,00,10,00,13,01,20,00,B1 with byte_valid toggling every other cycle -> writes at addr 0 (0x00100093) and addr 1 (0x00200113); done=1; no byte is accepted during WRITE.
- Bad checksum: single word with checksum byte 0x84 -> mem_we pulses once, then error=1, cpu_rst stays 1, done=0.
- Illegal length: start with word_count=0, then again with 1025 -> ERR on the next edge, with no mem_we and byte_ready=0 both times.
- Abort and reset: abort after 6 bytes of a 3-word load -> exactly one write (addr 0), then ERR. A new start then completes normally. Asserting rst during RECV returns all outputs to reset values on the next edge.
- Reload from DONE: after a successful load, start a 1-word load -> cpu_rst rises on the accepting edge and falls only after the matching checksum; a start pulse during busy has no effect.
